// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes and datapath select codes.
package mc_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the control unit knows how to sequence.
  function automatic logic opcode_known(input logic [OPCODE_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the multicycle control FSM.
module mc_next_state
  import mc_pkg::*;
(
  input  logic [STATE_W-1:0]  state_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [STATE_W-1:0]  state_o
);

  // Every path not listed, including unused encodings, returns to FETCH.
  always_comb begin
    state_o = FETCH;
    case (state_i)
      FETCH:   state_o = DECODE;
      DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: state_o = MEMADR;
          OP_RTYPE:     state_o = EXECUTE;
          OP_BEQ:       state_o = BRANCH;
          OP_ADDI:      state_o = ADDIEX;
          OP_J:         state_o = JUMP;
          default:      state_o = FETCH;
        endcase
      end
      MEMADR:  state_o = (opcode_i == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_o = MEMWB;
      EXECUTE: state_o = ALUWB;
      ADDIEX:  state_o = ADDIWB;
      default: state_o = FETCH;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback and drives datapath enables.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                pc_en,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic                iord,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [STATE_W-1:0]  state_out,
  output logic                illegal_op
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q, illegal_d;
  logic               pc_write, branch;

  mc_next_state u_next_state (
    .state_i  (state_q),
    .opcode_i (opcode),
    .state_o  (state_d)
  );

  // Sticky trap: set when DECODE sees an opcode it cannot sequence.
  always_comb begin
    illegal_d = illegal_q;
    if (TRAP_ILLEGAL && (state_q == DECODE) && !opcode_known(opcode)) begin
      illegal_d = 1'b1;
    end
  end

  // State and trap flag registers; reset aborts the instruction immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode; held at zero during reset so no write can slip through.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    if (!RST) begin
      case (state_q)
        FETCH: begin
          ir_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        DECODE:  alu_src_b = SRCB_IMM_SH2;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEMRD:   iord = 1'b1;
        MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          branch    = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ADDIWB:  reg_write = 1'b1;
        JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = pc_write | (branch & zero);
  end

  assign state_out  = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: trapping and non-trapping instances run side by side against a per-cycle scoreboard.
module tb_mc_control_fsm;

  typedef struct packed {
    logic pc_en, ir_write, mem_write, reg_write, iord, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      ctrl;
    logic       ill;
    logic [3:0] st_nt;
    ctrl_t      ctrl_nt;
    logic       ill_nt;
  } snap_t;

  typedef struct packed {
    snap_t      want;
    logic [5:0] op;
    logic       z;
  } item_t;

  logic       CLK, RST, zero;
  logic [5:0] opcode;

  logic       pc_en, ir_write, mem_write, reg_write, iord, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_out;
  logic       illegal_op;

  logic       n_pc_en, n_ir_write, n_mem_write, n_reg_write, n_iord, n_reg_dst, n_mem_to_reg, n_alu_src_a;
  logic [1:0] n_alu_src_b, n_alu_op, n_pc_src;
  logic [3:0] n_state_out;
  logic       n_illegal_op;

  snap_t obs;
  assign obs = {state_out,
                pc_en, ir_write, mem_write, reg_write, iord, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, alu_op, pc_src, illegal_op,
                n_state_out,
                n_pc_en, n_ir_write, n_mem_write, n_reg_write, n_iord, n_reg_dst, n_mem_to_reg, n_alu_src_a,
                n_alu_src_b, n_alu_op, n_pc_src, n_illegal_op};

  mc_control_fsm #(.TRAP_ILLEGAL(1'b1)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
    .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state_out(state_out), .illegal_op(illegal_op)
  );

  mc_control_fsm #(.TRAP_ILLEGAL(1'b0)) dut_nt (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
    .pc_en(n_pc_en), .ir_write(n_ir_write), .mem_write(n_mem_write), .reg_write(n_reg_write),
    .iord(n_iord), .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .pc_src(n_pc_src),
    .state_out(n_state_out), .illegal_op(n_illegal_op)
  );

  int    checks   = 0;
  int    failures = 0;
  logic  model_ill;
  item_t exp_q[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected control word for one state.
  function automatic ctrl_t mk_ctrl(input logic [3:0] s, input logic z);
    ctrl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.ir_write = 1'b1; c.pc_en = 1'b1; c.alu_src_b = 2'b01; end
      4'd1:  c.alu_src_b = 2'b11;
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  c.iord = 1'b1;
      4'd4:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      4'd5:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
      4'd9:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd10: c.reg_write = 1'b1;
      4'd11: begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic push_state(input logic [3:0] s, input logic [5:0] op, input logic z);
    item_t it;
    it.want.st      = s;
    it.want.ctrl    = mk_ctrl(s, z);
    it.want.ill     = model_ill;
    it.want.st_nt   = s;
    it.want.ctrl_nt = mk_ctrl(s, z);
    it.want.ill_nt  = 1'b0;
    it.op = op;
    it.z  = z;
    exp_q.push_back(it);
  endtask

  // Queue the expected per-cycle state walk of one instruction.
  task automatic push_instr(input logic [5:0] op, input logic z);
    push_state(4'd0, op, z);
    push_state(4'd1, op, z);
    case (op)
      6'b100011: begin push_state(4'd2, op, z); push_state(4'd3, op, z); push_state(4'd4, op, z); end
      6'b101011: begin push_state(4'd2, op, z); push_state(4'd5, op, z); end
      6'b000000: begin push_state(4'd6, op, z); push_state(4'd7, op, z); end
      6'b000100: push_state(4'd8, op, z);
      6'b001000: begin push_state(4'd9, op, z); push_state(4'd10, op, z); end
      6'b000010: push_state(4'd11, op, z);
      default:   model_ill = 1'b1;
    endcase
  endtask

  // Advance one cycle, drive that cycle's inputs and sample mid-cycle.
  task automatic step(output snap_t got, output snap_t want);
    item_t it;
    it = exp_q.pop_front();
    @(negedge CLK);
    opcode = it.op;
    zero   = it.z;
    #1;
    got  = obs;
    want = it.want;
  endtask

  task automatic test_reset();
    snap_t zs;
    zs = '0;
    RST = 1'b1; opcode = 6'b100011; zero = 1'b1; model_ill = 1'b0;
    #3;
    checks++;
    if (obs !== zs) begin failures++; $display("FAIL reset_initial: got=%h expected=%h", obs, zs); end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (obs !== zs) begin failures++; $display("FAIL reset_held: got=%h expected=%h", obs, zs); end
    @(posedge CLK);
    #2 RST = 1'b0;
  endtask

  task automatic test_mem();
    snap_t got, want;
    push_instr(6'b100011, 1'b0);
    push_instr(6'b101011, 1'b0);
    while (exp_q.size() != 0) begin
      step(got, want);
      checks++;
      if (got !== want) begin failures++; $display("FAIL lw_sw state=%0d: got=%h expected=%h", want.st, got, want); end
    end
  endtask

  task automatic test_alu();
    snap_t got, want;
    push_instr(6'b000000, 1'b0);
    push_instr(6'b001000, 1'b1);
    while (exp_q.size() != 0) begin
      step(got, want);
      checks++;
      if (got !== want) begin failures++; $display("FAIL rtype_addi state=%0d: got=%h expected=%h", want.st, got, want); end
    end
  endtask

  task automatic test_branch();
    snap_t got, want;
    push_instr(6'b000100, 1'b1);
    push_instr(6'b000100, 1'b0);
    while (exp_q.size() != 0) begin
      step(got, want);
      checks++;
      if (got !== want) begin failures++; $display("FAIL beq state=%0d: got=%h expected=%h", want.st, got, want); end
    end
  endtask

  task automatic test_jump();
    snap_t got, want;
    push_instr(6'b000010, 1'b0);
    push_instr(6'b000010, 1'b1);
    while (exp_q.size() != 0) begin
      step(got, want);
      checks++;
      if (got !== want) begin failures++; $display("FAIL jump state=%0d: got=%h expected=%h", want.st, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    snap_t      got, want;
    logic [5:0] ops [0:7];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b010101};
    for (int n = 0; n < 30; n++) begin
      push_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() != 0) begin
      step(got, want);
      checks++;
      if (got !== want) begin failures++; $display("FAIL back_to_back state=%0d: got=%h expected=%h", want.st, got, want); end
    end
  endtask

  task automatic test_illegal();
    snap_t got, want;
    push_instr(6'b111111, 1'b0);
    push_instr(6'b001000, 1'b0);
    push_instr(6'b110000, 1'b1);
    push_instr(6'b000000, 1'b0);
    while (exp_q.size() != 0) begin
      step(got, want);
      checks++;
      if (got !== want) begin failures++; $display("FAIL illegal state=%0d: got=%h expected=%h", want.st, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    snap_t got, want, zs;
    ctrl_t fc;
    zs = '0;
    push_instr(6'b101011, 1'b0);
    while (exp_q.size() != 0) begin
      step(got, want);
      checks++;
      if (got !== want) begin failures++; $display("FAIL reset_mid_pre state=%0d: got=%h expected=%h", want.st, got, want); end
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if (obs !== zs) begin failures++; $display("FAIL reset_mid_abort: got=%h expected=%h", obs, zs); end
    @(posedge CLK);
    #1;
    checks++;
    if (mem_write !== 1'b0 || state_out !== 4'd0) begin
      failures++; $display("FAIL reset_mid_hold: mem_write=%b state=%0d expected 0 and 0", mem_write, state_out);
    end
    @(posedge CLK);
    #2 RST = 1'b0;
    model_ill = 1'b0;
    @(negedge CLK);
    #1;
    fc = mk_ctrl(4'd0, zero);
    checks++;
    if (state_out !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1 || illegal_op !== 1'b0 || obs.ctrl !== fc) begin
      failures++; $display("FAIL reset_release_fetch: state=%0d ir_write=%b pc_en=%b ill=%b expected 0 1 1 0", state_out, ir_write, pc_en, illegal_op);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (state_out !== 4'd1) begin failures++; $display("FAIL reset_release_decode: state=%0d expected 1", state_out); end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_alu();
    test_branch();
    test_jump();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit that sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Produces the per-cycle write enables consumed directly by the datapath state registers (PC, IR, MDR, A/B, ALUOut) and register file, plus datapath mux selects.
- Sits immediately upstream of the enable-gated 32-bit state registers; its pc_en output drives the PC register EN.

Parameters:
- TRAP_ILLEGAL, 1, 1: an unknown opcode sets the sticky illegal_op flag. 0: an unknown opcode executes as a NOP and illegal_op stays 0.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26], valid from the DECODE cycle onward.
- zero  input  1  ALU zero flag, sampled combinationally in BRANCH.
- pc_en  output  1  PC register enable = pc_write | (branch & zero).
- ir_write  output  1  IR register enable.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write enable.
- iord  output  1  memory address select (0 = PC, 1 = ALUOut).
- reg_dst  output  1  write-register select (0 = rt, 1 = rd).
- mem_to_reg  output  1  writeback source (0 = ALUOut, 1 = MDR).
- alu_src_a  output  1  ALU A select (0 = PC, 1 = A).
- alu_src_b  output  2  ALU B select (00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2).
- alu_op  output  2  00 = add, 01 = sub, 10 = decode funct.
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state_out  output  4  current state encoding, for debug and the bench.
- illegal_op  output  1  sticky illegal-opcode flag.

Behaviour:
- Moore FSM with a 4-bit state register; all outputs decode from state only, except pc_en, which also uses zero.
- Reset (async): state <= FETCH and illegal_op <= 0 immediately. While RST = 1, pc_en, ir_write, mem_write and reg_write are forced to 0 and all selects are 0.
- First FETCH cycle after RST deasserts: its enables are active on the first CLK edge.
- Unconditional transitions, each taking one cycle:
  - FETCH: iord = 0, ir_write = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00, pc_write = 1. -> DECODE.
  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (beq) -> BRANCH.
    - 001000 (addi) -> ADDIEX.
    - 000010 (j) -> JUMP.
    - Other opcodes -> FETCH, with illegal_op <= 1 if TRAP_ILLEGAL = 1.
  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord = 1. -> MEMWB.
  - MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. -> FETCH.
  - MEMWR: iord = 1, mem_write = 1. -> FETCH.
  - EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> ALUWB.
  - ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. -> FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, branch = 1. -> FETCH.
  - ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. -> ADDIWB.
  - ADDIWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1. -> FETCH.
  - JUMP: pc_src = 10, pc_write = 1. -> FETCH.
- Any unused state encoding returns to FETCH on the next edge. Outputs in an unused encoding are all 0.
- CPI by instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Mid-instruction reset aborts immediately; no partial write occurs after RST rises.
- illegal_op is cleared only by RST.
- opcode is sampled in DECODE and MEMADR only. It must stay stable because IR is not written outside FETCH.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11;
  - opcode constants;
  - alu_op, alu_src_b and pc_src codes.
- Natural sub-module: mc_next_state, a purely combinational next-state function of (state, opcode). Output decode stays in the top module.

Test Plan:
- Assert RST mid-cycle while in MEMWR -> state_out = 0 at once, mem_write = 0 while RST = 1. After release, first edge has ir_write = 1 and pc_en = 1.
- opcode = 100011 (lw) -> states 0,1,2,3,4,0 over 5 clocks. reg_write = 1 and mem_to_reg = 1 only in the MEMWB cycle.
- opcode = 000100 (beq): zero = 1 in BRANCH -> pc_en = 1, pc_src = 01. With zero = 0 -> pc_en = 0. Either way back to FETCH after 3 cycles.
- opcode = 000000 (R-type) -> EXECUTE with alu_op = 10, then ALUWB with reg_dst = 1 and reg_write = 1, 4 cycles total.
- opcode = 111111 with TRAP_ILLEGAL = 1 -> DECODE then FETCH, illegal_op = 1 and it holds through a following valid addi. With TRAP_ILLEGAL = 0 -> illegal_op stays 0.
- opcode = 000010 (j) -> JUMP with pc_src = 10 and pc_en = 1. No reg_write or mem_write in any of the 3 cycles.
